adder_share_arbiter: RTL and testbench

Round-robin scheduler that shares one external combinational 32-bit ripple-carry adder among NUM_REQ requesters inside the RISC-V PE. It accepts one request at a time with a valid/ready handshake and sequences the adder for one pass (32-bit add) or two passes (64-bit add, low half then high half with carry chained through a register). It returns a registered result with the requester ID.

---
 rtl/adder_share_arbiter_if.sv | 48 ++++
 rtl/adder_share_arbiter.sv | 137 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Handshake and adder bundle between the requesters, the shared adder and adder_share_arbiter.
// Ports: req_* carry per-requester valid/ready, mode, carry-in and packed 64-bit operands;
//        add_* drive and return the external combinational adder; rsp_* return the result.
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_wide;
  logic [NUM_REQ-1:0]          req_cin;
  logic [NUM_REQ*2*DATA_W-1:0] req_a;
  logic [NUM_REQ*2*DATA_W-1:0] req_b;

  logic [DATA_W-1:0]           add_a;
  logic [DATA_W-1:0]           add_b;
  logic                        add_cin;
  logic [DATA_W-1:0]           add_sum;
  logic                        add_cout;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [2*DATA_W-1:0]         rsp_sum;
  logic                        rsp_cout;

  // Environment side: requesters, external adder and response consumer.
  modport master (
    output req_valid, req_wide, req_cin, req_a, req_b,
    input  req_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_wide, req_cin, req_a, req_b,
    output req_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  rsp_ready
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one external 32-bit adder; one request in flight, 32- or 64-bit adds.
// Latency: accept to rsp_valid is 2 cycles narrow, 3 cycles wide; accepts only in IDLE.
// Backpressure: rsp_ready low holds the result stable; req_ready stays 0 until the response drains.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries req_*, add_* and rsp_* groups.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     gnt_id;
  logic                found;
  logic                accept;
  logic [NUM_REQ-1:0]  ready;
  logic [2*DATA_W-1:0] sel_a;
  logic [2*DATA_W-1:0] sel_b;
  int                  idx;

  // Only the upper halves need keeping: the lower halves go straight into the adder operand registers.
  logic [DATA_W-1:0]   a_hi_q;
  logic [DATA_W-1:0]   b_hi_q;
  logic                wide_q;

  logic [DATA_W-1:0]   add_a_q;
  logic [DATA_W-1:0]   add_b_q;
  logic                add_cin_q;   // in HI this holds the carry chained from the low pass
  logic                rsp_valid_q;
  logic [2*DATA_W-1:0] rsp_sum_q;
  logic                rsp_cout_q;
  logic [ID_W-1:0]     rsp_id_q;

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  assign accept = (state == IDLE) && found;
  assign sel_a  = bus.req_a[int'(gnt_id)*2*DATA_W +: 2*DATA_W];
  assign sel_b  = bus.req_b[int'(gnt_id)*2*DATA_W +: 2*DATA_W];

  always_comb begin
    ready = '0;
    if (accept) ready[gnt_id] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      wide_q      <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_hi_q     <= sel_a[2*DATA_W-1:DATA_W];
            b_hi_q     <= sel_b[2*DATA_W-1:DATA_W];
            wide_q     <= bus.req_wide[gnt_id];
            add_a_q    <= sel_a[DATA_W-1:0];
            add_b_q    <= sel_b[DATA_W-1:0];
            add_cin_q  <= bus.req_cin[gnt_id];
            last_grant <= gnt_id;
            rsp_id_q   <= gnt_id;
            state      <= LO;
          end
        end
        LO: begin
          rsp_sum_q[DATA_W-1:0] <= bus.add_sum;
          if (wide_q) begin
            add_a_q   <= a_hi_q;
            add_b_q   <= b_hi_q;
            add_cin_q <= bus.add_cout;
            state     <= HI;
          end else begin
            rsp_sum_q[2*DATA_W-1:DATA_W] <= '0;
            rsp_cout_q  <= bus.add_cout;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
        end
        HI: begin
          rsp_sum_q[2*DATA_W-1:DATA_W] <= bus.add_sum;
          rsp_cout_q  <= bus.add_cout;
          add_a_q     <= '0;
          add_b_q     <= '0;
          add_cin_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural 32-bit adder closing the add_* loop.
module tb_adder_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W:0] add_full;
  assign add_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{DATA_W{1'b0}}, bus.add_cin};
  assign bus.add_sum  = add_full[DATA_W-1:0];
  assign bus.add_cout = add_full[DATA_W];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single request from one requester, checking latency cycle by cycle; rsp_ready assumed high.
  task automatic run_op(input string name, input int id, input bit wide,
                        input logic [63:0] a, input logic [63:0] b, input bit cin,
                        input logic [63:0] exp_sum, input bit exp_cout);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    bus.req_a[id*64 +: 64] = a;
    bus.req_b[id*64 +: 64] = b;
    bus.req_wide[id]  = wide;
    bus.req_cin[id]   = cin;
    bus.req_valid[id] = 1'b1;
    #1 chk({name, "_ready"}, bus.req_ready, onehot);
    tick;
    bus.req_valid[id] = 1'b0;
    chk({name, "_lo_add_a"}, bus.add_a, a[31:0]);
    chk({name, "_lo_valid"}, bus.rsp_valid, 0);
    if (wide) begin
      tick;
      chk({name, "_hi_add_a"}, bus.add_a, a[63:32]);
      chk({name, "_hi_valid"}, bus.rsp_valid, 0);
    end
    tick;
    chk({name, "_valid"}, bus.rsp_valid, 1);
    chk({name, "_sum"},   bus.rsp_sum, exp_sum);
    chk({name, "_cout"},  bus.rsp_cout, exp_cout);
    chk({name, "_id"},    bus.rsp_id, id);
    chk({name, "_idle_add"}, bus.add_a, 0);
    tick;
    chk({name, "_drained"}, bus.rsp_valid, 0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] onehot;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_wide  = '0;
    bus.req_cin   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_sum",   bus.rsp_sum, 0);
    chk("rst_cout",  bus.rsp_cout, 0);
    chk("rst_id",    bus.rsp_id, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_add",   {bus.add_cin, bus.add_b, bus.add_a}, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_no_req", bus.req_ready, 0);

    run_op("n5p3",    0, 1'b0, 64'd5,  64'd3,  1'b0, 64'd8,  1'b0);
    run_op("n15p27",  0, 1'b0, 64'd15, 64'd27, 1'b1, 64'd43, 1'b0);
    run_op("w_chain", 0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    run_op("w_wrap",  0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    run_op("n_ovf",   2, 1'b0, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 1'b1);

    // Fairness: all four requesters held valid from reset.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*64 +: 64] = 64'(i);
      bus.req_b[i*64 +: 64] = 64'd10;
    end
    bus.req_wide  = '0;
    bus.req_cin   = '0;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % NUM_REQ;
      onehot = '0;
      onehot[e] = 1'b1;
      #1 chk("rr_grant", bus.req_ready, onehot);
      tick;
      chk("rr_pulse", bus.req_ready, 0);
      tick;
      chk("rr_valid", bus.rsp_valid, 1);
      chk("rr_id",    bus.rsp_id, e);
      chk("rr_sum",   bus.rsp_sum, 64'(e + 10));
      tick;
    end
    bus.req_valid = '0;

    // Backpressure: requester 1 wins (last grant was 0), response held 5 cycles.
    bus.req_a[64 +: 64] = 64'd100;
    bus.req_b[64 +: 64] = 64'd23;
    bus.rsp_ready = 1'b0;
    bus.req_valid[1] = 1'b1;
    #1 chk("bp_grant", bus.req_ready, 4'b0010);
    tick;
    bus.req_valid = '0;
    tick;
    bus.req_valid = '1;
    repeat (5) begin
      #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_sum",   bus.rsp_sum, 64'd123);
      chk("bp_ready", bus.req_ready, 0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #1 chk("bp_release_id", bus.rsp_id, 1);
    tick;
    chk("bp_done", bus.rsp_valid, 0);

    // Reset during the high pass of a wide op from requester 3.
    bus.req_a[192 +: 64] = 64'h1234_5678_9ABC_DEF0;
    bus.req_b[192 +: 64] = 64'd1;
    bus.req_wide[3]  = 1'b1;
    bus.req_valid[3] = 1'b1;
    #1 chk("mr_grant", bus.req_ready, 4'b1000);
    tick;
    bus.req_valid = '0;
    tick;
    chk("mr_hi_add_a", bus.add_a, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", bus.rsp_valid, 0);
    chk("mr_add",   {bus.add_cin, bus.add_b, bus.add_a}, 0);
    chk("mr_sum",   bus.rsp_sum, 0);
    chk("mr_id",    bus.rsp_id, 0);
    chk("mr_cout",  bus.rsp_cout, 0);
    tick;
    tick;
    chk("mr_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    tick;
    bus.req_a[0 +: 64] = 64'd7;
    bus.req_b[0 +: 64] = 64'd9;
    bus.req_wide  = '0;
    bus.req_valid = 4'b1001;
    #1 chk("mr_first", bus.req_ready, 4'b0001);
    tick;
    bus.req_valid = '0;
    tick;
    chk("mr_post_valid", bus.rsp_valid, 1);
    chk("mr_post_id",    bus.rsp_id, 0);
    chk("mr_post_sum",   bus.rsp_sum, 64'd16);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
